// File: rtl/dffram_pkg.sv
// Shared types and helpers for the DFF-based register file: sequencer states,
// address range checking/aliasing and per-lane word merging.
package dffram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int unsigned MAX_AW = 32;
    localparam int unsigned MAX_DW = 64;

    function automatic logic addr_valid(input logic [MAX_AW-1:0] addr, input int unsigned depth);
        return (addr < 32'(depth));
    endfunction

    // Out-of-range addresses alias to word 0
    function automatic logic [MAX_AW-1:0] xlat(input logic [MAX_AW-1:0] addr, input int unsigned depth);
        logic [MAX_AW-1:0] idx;
        if (addr_valid(addr, depth)) begin
            idx = addr;
        end else begin
            idx = '0;
        end
        return idx;
    endfunction

    function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_word,
                                                      input logic [MAX_DW-1:0] new_word,
                                                      input logic [MAX_DW-1:0] lane_en,
                                                      input int unsigned       lw);
        logic [MAX_DW-1:0] res;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (lane_en[i / lw]) begin
                res[i] = new_word[i];
            end else begin
                res[i] = old_word[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dffram_rport.sv
// One read port: address aliasing, storage mux, write-through merge,
// clear forcing and an optional one-cycle output buffer.
module dffram_rport
    import dffram_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DEPTH  = 18,
    parameter int unsigned LANES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idle,
    input  logic [DWIDTH-1:0] mem [DEPTH],
    input  logic [AWIDTH-1:0] r_addr,
    input  logic              rbuf_mode,
    input  logic              wthru,
    input  logic              w_en,
    input  logic [AWIDTH-1:0] w_addr,
    input  logic [DWIDTH-1:0] w_data,
    input  logic [LANES-1:0]  w_lane,
    output logic [DWIDTH-1:0] r_data
);

    localparam int unsigned LW = DWIDTH / LANES;

    logic [AWIDTH-1:0] idx_s;
    logic [DWIDTH-1:0] word_s;
    logic [DWIDTH-1:0] merged_s;
    logic              bypass_s;
    logic [DWIDTH-1:0] cur_s;
    logic [DWIDTH-1:0] rbuf_r;

    assign idx_s    = AWIDTH'(xlat(32'(r_addr), DEPTH));
    assign word_s   = mem[idx_s];
    assign merged_s = DWIDTH'(lane_merge(64'(word_s), 64'(w_data), 64'(w_lane), LW));
    assign bypass_s = wthru && idle && w_en && addr_valid(32'(w_addr), DEPTH) && (idx_s == w_addr);

    // Current read value: zero while clearing, merged on write-through hit
    always_comb begin
        cur_s = '0;
        if (!idle) begin
            cur_s = '0;
        end else if (bypass_s) begin
            cur_s = merged_s;
        end else begin
            cur_s = word_s;
        end
    end

    // Optional output buffer, one cycle behind the current value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf_r <= '0;
        end else begin
            rbuf_r <= cur_s;
        end
    end

    assign r_data = rbuf_mode ? rbuf_r : cur_s;

endmodule

// File: rtl/dffram_regfile_nr1w.sv
// DFF register file with one lane-masked write port, NRPORTS read ports and
// a clear sequencer that zeroes every word after reset or on clr_req.
module dffram_regfile_nr1w
    import dffram_pkg::*;
#(
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned AWIDTH  = 5,
    parameter int unsigned DEPTH   = 18,
    parameter int unsigned NRPORTS = 2,
    parameter int unsigned LANES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_req,
    output logic                        ready,
    input  logic                        w_en,
    input  logic [AWIDTH-1:0]           w_addr,
    input  logic [DWIDTH-1:0]           w_data,
    input  logic [LANES-1:0]            w_lane,
    input  logic                        wthru,
    input  logic [NRPORTS-1:0]          rbuf_mode,
    input  logic [NRPORTS*AWIDTH-1:0]   r_addr,
    output logic [NRPORTS*DWIDTH-1:0]   r_data
);

    localparam int unsigned LW = DWIDTH / LANES;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [AWIDTH-1:0] cnt_r;
    logic [AWIDTH-1:0] cnt_nxt_s;
    logic              ready_r;
    logic              idle_s;
    logic              last_s;
    logic              wr_we_s;
    logic [DWIDTH-1:0] mem_r [DEPTH];

    assign idle_s  = (state_r == ST_IDLE);
    assign last_s  = (cnt_r == AWIDTH'(DEPTH - 1));
    assign wr_we_s = idle_s && w_en && addr_valid(32'(w_addr), DEPTH);
    assign ready   = ready_r;

    // Clear sequencer next-state: sweep every word once, then idle until clr_req
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = cnt_r + AWIDTH'(1'b1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                cnt_nxt_s = '0;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Sequencer state, sweep counter and registered ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Storage: sweep zeroes one word per cycle, otherwise lane-masked write
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!idle_s && (cnt_r == AWIDTH'(i))) begin
                mem_r[i] <= '0;
            end else if (wr_we_s && (w_addr == AWIDTH'(i))) begin
                mem_r[i] <= DWIDTH'(lane_merge(64'(mem_r[i]), 64'(w_data), 64'(w_lane), LW));
            end
        end
    end

    for (genvar p = 0; p < NRPORTS; p++) begin : g_rport
        dffram_rport #(
            .DWIDTH (DWIDTH),
            .AWIDTH (AWIDTH),
            .DEPTH  (DEPTH),
            .LANES  (LANES)
        ) u_rport (
            .clk       (clk),
            .rst       (rst),
            .idle      (idle_s),
            .mem       (mem_r),
            .r_addr    (r_addr[p*AWIDTH +: AWIDTH]),
            .rbuf_mode (rbuf_mode[p]),
            .wthru     (wthru),
            .w_en      (w_en),
            .w_addr    (w_addr),
            .w_data    (w_data),
            .w_lane    (w_lane),
            .r_data    (r_data[p*DWIDTH +: DWIDTH])
        );
    end

endmodule
